// File: rtl/imem_access_arbiter_if.sv
// Bus bundle between the IF stage / program loader and the instruction memory arbiter.
// The slave modport is the arbiter's view; the master modport is the requester + memory side.
interface imem_access_arbiter_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 boot;
    logic                 if_req;
    logic [31:0]          if_addr;
    logic                 if_gnt;
    logic                 if_rvalid;
    logic [31:0]          if_rdata;
    logic                 if_err;
    logic                 ld_req;
    logic [31:0]          ld_addr;
    logic [31:0]          ld_wdata;
    logic [3:0]           ld_be;
    logic                 ld_gnt;
    logic                 ld_err;
    logic [31:0]          mem_addr;
    logic                 mem_we;
    logic [3:0]           mem_be;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;
    logic [ERR_CNT_W-1:0] err_cnt;

    // Handshake: if_req/ld_req are levels held until the matching one-cycle gnt pulse;
    // a request dropped before gnt is simply forgotten. if_rdata/if_err are qualified by
    // if_rvalid, ld_err by ld_gnt.
    modport slave (
        input  boot, if_req, if_addr, ld_req, ld_addr, ld_wdata, ld_be, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err, ld_gnt, ld_err,
               mem_addr, mem_we, mem_be, mem_wdata, err_cnt
    );

    modport master (
        output boot, if_req, if_addr, ld_req, ld_addr, ld_wdata, ld_be, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err, ld_gnt, ld_err,
               mem_addr, mem_we, mem_be, mem_wdata, err_cnt
    );
endinterface

// File: rtl/imem_access_arbiter.sv
// Shares the synchronous-read instruction memory between IF-stage fetches and loader writes.
// Define IMEM_ARB_RR_EN to alternate grants under contention instead of fixed loader priority.
module imem_access_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int ERR_CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    imem_access_arbiter_if.slave       bus,
    output logic [1:0]                 dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, CAP = 2'd2, WR = 2'd3} state_t;

    state_t               state_q, state_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic [3:0]           mem_be_q, mem_be_d;
    logic                 mem_we_q, mem_we_d;
    logic [31:0]          if_rdata_q, if_rdata_d;
    logic                 if_err_q, if_err_d;
    logic                 if_rvalid_q, if_rvalid_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 err_inc;
    logic                 fetch_cand, ld_cand, pick_ld;

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a > 32'(MEM_BYTES - 4));
    endfunction

    assign fetch_cand = bus.if_req && !bus.boot;
    assign ld_cand    = bus.ld_req;

`ifdef IMEM_ARB_RR_EN
    // last_ld_q: 1 = loader won the previous arbitration, 0 = fetch (reset value).
    logic last_ld_q, last_ld_d;

    assign pick_ld = ld_cand && (!fetch_cand || !last_ld_q);

    always_comb begin
        last_ld_d = last_ld_q;
        if (state_q == IDLE && (ld_cand || fetch_cand)) last_ld_d = pick_ld;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_ld_q <= 1'b0;
        else     last_ld_q <= last_ld_d;
    end
`else
    assign pick_ld = ld_cand;
`endif

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        mem_we_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        if_err_d    = if_err_q;
        if_rvalid_d = 1'b0;
        err_inc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_ld) begin
                    state_d     = WR;
                    mem_addr_d  = bus.ld_addr;
                    mem_wdata_d = bus.ld_wdata;
                    mem_be_d    = bus.ld_be;
                    // Dropped writes still present addr/data/be, but never strobe the array.
                    mem_we_d    = !bad_addr(bus.ld_addr) && (bus.ld_be != 4'b0000);
                end else if (fetch_cand) begin
                    state_d    = RD;
                    mem_addr_d = bus.if_addr;
                end
            end
            RD: state_d = CAP;
            CAP: begin
                state_d     = IDLE;
                if_rvalid_d = 1'b1;
                if_err_d    = bad_addr(mem_addr_q);
                if_rdata_d  = bad_addr(mem_addr_q) ? 32'h0 : bus.mem_rdata;
                err_inc     = bad_addr(mem_addr_q);
            end
            WR: begin
                state_d = IDLE;
                err_inc = bad_addr(mem_addr_q);
            end
            default: state_d = IDLE;
        endcase
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_we_q    <= 1'b0;
            if_rdata_q  <= 32'h0;
            if_err_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            mem_we_q    <= mem_we_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            if_rvalid_q <= if_rvalid_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.if_gnt    = (state_q == RD);
    assign bus.ld_gnt    = (state_q == WR);
    assign bus.ld_err    = (state_q == WR) && bad_addr(mem_addr_q);
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.err_cnt   = err_cnt_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_imem_access_arbiter.sv
// Bench for imem_access_arbiter: directed cases plus random traffic against a
// transaction-level model (byte-array memory, busy-until arbitration timing).
module tb_imem_access_arbiter;
  localparam int MEM_BYTES = 1024;
  localparam int ERR_W     = 5;
  localparam int ERR_MAX   = (1 << ERR_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  imem_access_arbiter_if #(.ERR_CNT_W(ERR_W)) bus ();

  imem_access_arbiter #(.MEM_BYTES(MEM_BYTES), .ERR_CNT_W(ERR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // ---------------- memory array driven by the DUT ----------------
  logic [7:0] mem_arr [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];

  always @(posedge clk) begin
    if (bus.mem_we)
      for (int k = 0; k < 4; k++)
        if (bus.mem_be[k]) mem_arr[10'(bus.mem_addr + 32'(k))] <= bus.mem_wdata[8*k +: 8];
    bus.mem_rdata <= {mem_arr[10'(bus.mem_addr + 32'd3)], mem_arr[10'(bus.mem_addr + 32'd2)],
                      mem_arr[10'(bus.mem_addr + 32'd1)], mem_arr[10'(bus.mem_addr)]};
  end

  // ---------------- scoreboard state ----------------
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [32:0] exp_q[$];
  logic [32:0] last_rd;
  int unsigned edge_n, free_edge, err_model;
  bit          last_ld;
  bit          if_won, ld_won, if_hold, ld_hold, rand_en;
  bit          exp_ig[8], exp_lg[8], exp_le[8], exp_rv[8], exp_we[8], exp_ma_v[8];
  logic [31:0] exp_ma[8], exp_wd[8];
  logic [3:0]  exp_wb[8];
  int unsigned exp_einc[8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a > MEM_BYTES - 4);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w = 32'h0;
    for (int k = 0; k < 4; k++) w = w | (32'(ref_mem[a + k]) << (8 * k));
    return w;
  endfunction

  function automatic logic [31:0] gen_addr();
    int unsigned r = $urandom_range(0, 9);
    logic [31:0] a = 32'($urandom_range(0, 63)) * 4;
    if (r == 0) a = a + 32'($urandom_range(1, 3));
    else if (r == 1) a = 32'(MEM_BYTES + 4 * $urandom_range(0, 100));
    else if (r == 2) a = 32'(MEM_BYTES - 4);
    return a;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) begin
      exp_ig[i] = 0; exp_lg[i] = 0; exp_le[i] = 0; exp_rv[i] = 0;
      exp_we[i] = 0; exp_ma_v[i] = 0; exp_einc[i] = 0;
    end
    exp_q.delete();
    err_model = 0;
    last_ld   = 0;
    free_edge = edge_n;
  endtask

  // ---------------- one clock: model decision, DUT checks, agent update ----------------
  task automatic step();
    int unsigned s, sf;
    logic [31:0] a;
    bit fc, lc, pick_ld, bad;
    if_won = 0;
    ld_won = 0;
    @(posedge clk);
    if (edge_n >= free_edge) begin
      fc = bus.if_req && !bus.boot;
      lc = bus.ld_req;
`ifdef IMEM_ARB_RR_EN
      if (fc && lc) pick_ld = !last_ld;
      else          pick_ld = lc;
`else
      pick_ld = lc;
`endif
      s = edge_n % 8;
      if (pick_ld) begin
        a = bus.ld_addr;
        bad = is_bad(a);
        exp_lg[s] = 1; exp_le[s] = bad; exp_ma_v[s] = 1; exp_ma[s] = a;
        exp_we[s] = !bad && (bus.ld_be != 4'h0);
        exp_wd[s] = bus.ld_wdata; exp_wb[s] = bus.ld_be;
        if (exp_we[s])
          for (int k = 0; k < 4; k++) if (bus.ld_be[k]) ref_mem[a + k] = bus.ld_wdata[8*k +: 8];
        if (bad) exp_einc[(edge_n + 1) % 8]++;
        free_edge = edge_n + 2;
        ld_won = 1;
        last_ld = 1;
      end else if (fc) begin
        a = bus.if_addr;
        bad = is_bad(a);
        exp_ig[s] = 1; exp_ma_v[s] = 1; exp_ma[s] = a;
        sf = (edge_n + 2) % 8;
        exp_rv[sf] = 1;
        if (bad) exp_einc[sf]++;
        exp_q.push_back({bad, bad ? 32'h0 : ref_word(a)});
        free_edge = edge_n + 3;
        if_won = 1;
        last_ld = 0;
      end
    end
    @(negedge clk);
    s = edge_n % 8;
    check("if_gnt", bus.if_gnt, exp_ig[s]);
    check("ld_gnt", bus.ld_gnt, exp_lg[s]);
    check("ld_err", bus.ld_err, exp_le[s]);
    check("if_rvalid", bus.if_rvalid, exp_rv[s]);
    check("mem_we", bus.mem_we, exp_we[s]);
    if (exp_ma_v[s]) check("mem_addr", bus.mem_addr, exp_ma[s]);
    if (exp_we[s]) begin
      check("mem_be", bus.mem_be, exp_wb[s]);
      check("mem_wdata", bus.mem_wdata, exp_wd[s]);
    end
    if (bus.if_rvalid) begin
      last_rd = {bus.if_err, bus.if_rdata};
      if (exp_q.size() != 0) check("if_rdata_err", last_rd, exp_q.pop_front());
    end
    err_model = err_model + exp_einc[s];
    if (err_model > ERR_MAX) err_model = ERR_MAX;
    check("err_cnt", bus.err_cnt, err_model);
    exp_ig[s] = 0; exp_lg[s] = 0; exp_le[s] = 0; exp_rv[s] = 0;
    exp_we[s] = 0; exp_ma_v[s] = 0; exp_einc[s] = 0;
    edge_n++;
    // requester agents
    if (rand_en) begin
      if (bus.if_req && (if_won || $urandom_range(0, 19) == 0)) bus.if_req = 0;
      else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1; bus.if_addr = gen_addr();
      end
      if (bus.ld_req && (ld_won || $urandom_range(0, 19) == 0)) bus.ld_req = 0;
      else if (!bus.ld_req && $urandom_range(0, 3) == 0) begin
        bus.ld_req = 1; bus.ld_addr = gen_addr();
        bus.ld_wdata = $urandom(); bus.ld_be = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 29) == 0) bus.boot = !bus.boot;
    end else begin
      if (if_won && !if_hold) bus.if_req = 0;
      if (ld_won && !ld_hold) bus.ld_req = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_to_grant(input bit want_ld);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = want_ld ? ld_won : if_won;
    end
    check(want_ld ? "ld_grant_wait" : "if_grant_wait", 64'(got), 64'd1);
  endtask

  task automatic do_fetch(input logic [31:0] a);
    bus.if_addr = a;
    bus.if_req  = 1;
    run_to_grant(0);
    repeat (3) step();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.ld_addr = a; bus.ld_wdata = d; bus.ld_be = be;
    bus.ld_req  = 1;
    run_to_grant(1);
    repeat (2) step();
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_if_gnt"},    bus.if_gnt,    0);
    check({pfx, "_if_rvalid"}, bus.if_rvalid, 0);
    check({pfx, "_if_rdata"},  bus.if_rdata,  0);
    check({pfx, "_if_err"},    bus.if_err,    0);
    check({pfx, "_ld_gnt"},    bus.ld_gnt,    0);
    check({pfx, "_ld_err"},    bus.ld_err,    0);
    check({pfx, "_mem_addr"},  bus.mem_addr,  0);
    check({pfx, "_mem_we"},    bus.mem_we,    0);
    check({pfx, "_mem_be"},    bus.mem_be,    0);
    check({pfx, "_mem_wdata"}, bus.mem_wdata, 0);
    check({pfx, "_err_cnt"},   bus.err_cnt,   0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.boot = 0; bus.if_req = 0; bus.if_addr = 0;
    bus.ld_req = 0; bus.ld_addr = 0; bus.ld_wdata = 0; bus.ld_be = 0;
    if_hold = 0; ld_hold = 0; rand_en = 0; last_rd = '0;
    for (int i = 0; i < MEM_BYTES; i++) begin
      mem_arr[i] = 8'($urandom());
      ref_mem[i] = mem_arr[i];
    end
    mem_arr[16'h10] = 8'h78; mem_arr[16'h11] = 8'h56; mem_arr[16'h12] = 8'h34; mem_arr[16'h13] = 8'h12;
    mem_arr[16'h20] = 8'h11; mem_arr[16'h21] = 8'h22; mem_arr[16'h22] = 8'h33; mem_arr[16'h23] = 8'h44;
    for (int i = 16'h10; i < 16'h24; i++) ref_mem[i] = mem_arr[i];

    repeat (2) @(negedge clk);
    check_outputs_zero("por");
    rst = 0;
    edge_n = 0;
    clear_model();

    do_fetch(32'h10);
    check("fetch_0x10", last_rd, {1'b0, 32'h1234_5678});
    do_write(32'h20, 32'hAABB_CCDD, 4'b0101);
    do_fetch(32'h20);
    check("masked_word", last_rd, {1'b0, 32'h44BB_22DD});
    do_fetch(32'h22);
    check("fetch_misaligned", last_rd, {1'b1, 32'h0});
    do_write(32'h3FE, 32'hDEAD_BEEF, 4'hF);
    check("err_cnt_two", bus.err_cnt, 2);
    do_fetch(32'h3FC);
    check("fetch_top_word_err", last_rd[32], 0);
    do_fetch(32'h400);
    check("fetch_past_end", last_rd, {1'b1, 32'h0});
    do_write(32'h30, 32'h1234_5678, 4'h0);
    do_fetch(32'h30);

    // contention: both requesters hold their request across grants
    bus.if_addr = 32'h10; bus.ld_addr = 32'h40; bus.ld_wdata = 32'hCAFE_F00D; bus.ld_be = 4'hF;
    if_hold = 1; ld_hold = 1; bus.if_req = 1; bus.ld_req = 1;
    repeat (8) step();
    ld_hold = 0;
    repeat (8) step();
    if_hold = 0;
    bus.if_req = 0; bus.ld_req = 0;
    repeat (4) step();

    // boot mode: fetch held but ignored, loader still served
    bus.boot = 1; bus.if_addr = 32'h40; bus.if_req = 1; if_hold = 1;
    repeat (6) step();
    do_write(32'h44, 32'h0BAD_F00D, 4'hF);
    repeat (3) step();
    bus.boot = 0; if_hold = 0;
    run_to_grant(0);
    repeat (3) step();

    // random traffic
    rand_en = 1;
    repeat (600) step();
    rand_en = 0;
    bus.if_req = 0; bus.ld_req = 0; bus.boot = 0;
    repeat (4) step();

    // reset while a fetch sits in its capture cycle
    bus.if_addr = 32'h10; bus.if_req = 1;
    run_to_grant(0);
    step();
    #2 rst = 1;
    #1 check_outputs_zero("rst_cap");
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    edge_n++;
    clear_model();
    check("rst_cap_no_rvalid", bus.if_rvalid, 0);
    repeat (2) step();
    do_fetch(32'h10);
    check("fetch_after_rst", last_rd, {1'b0, 32'h1234_5678});

    // counter saturation
    for (int i = 0; i < ERR_MAX + 2; i++) do_write(32'h3FE, 32'h0, 4'hF);
    check("err_cnt_saturated", bus.err_cnt, {ERR_W{1'b1}});
    do_fetch(32'h401);
    check("err_cnt_held", bus.err_cnt, {ERR_W{1'b1}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
